// File: rtl/encode_packet_flex.sv
// encode_packet_flex: serialises payload plus destination address into headered flits with valid/ready backpressure
module encode_packet_flex #(
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int FLIT_WIDTH = 64,
  parameter int TTL_WIDTH  = 2,
  parameter int SEQ_WIDTH  = 5,
  parameter int SRC_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] in_dst_addr,
  input  logic [TTL_WIDTH-1:0]  cfg_ttl,
  input  logic [SRC_WIDTH-1:0]  cfg_src_id,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FLIT_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  encode_done,
  output logic                  drop_pulse
);
  localparam int PAY_W     = FLIT_WIDTH - TTL_WIDTH - SEQ_WIDTH - SRC_WIDTH;
  localparam int FRAME_W   = DATA_WIDTH + ADDR_WIDTH;
  localparam int NUM_FLITS = (FRAME_W + PAY_W - 1) / PAY_W;
  localparam int PAD_W     = NUM_FLITS * PAY_W;

  if (NUM_FLITS > 2**SEQ_WIDTH || PAY_W < 1) begin : g_bad_params
    $error("encode_packet_flex: flit geometry does not fit the header fields");
  end

  typedef enum logic [1:0] {IDLE, SEND, DROP} state_t;

  state_t                 state;
  logic [FRAME_W-1:0]     frame;
  logic [TTL_WIDTH-1:0]   ttl;
  logic [SRC_WIDTH-1:0]   src;
  logic [SEQ_WIDTH-1:0]   seq;
  logic [PAD_W-1:0]       pad;
  logic                   last;

  // frame is zero-extended so the final flit's unused payload bits read as zero
  assign pad       = PAD_W'(frame);
  assign last      = seq == SEQ_WIDTH'(NUM_FLITS - 1);
  assign in_ready  = rst_n && state == IDLE;
  assign out_valid = state == SEND;
  assign out_last  = out_valid && last;
  assign out_data  = out_valid ? {pad[int'(seq)*PAY_W +: PAY_W], ttl, seq, src} : '0;
  assign busy      = state != IDLE;
  assign drop_pulse = state == DROP;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      frame       <= '0;
      ttl         <= '0;
      src         <= '0;
      seq         <= '0;
      encode_done <= 1'b0;
    end else begin
      encode_done <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          frame <= {in_data, in_dst_addr};
          ttl   <= cfg_ttl;
          src   <= cfg_src_id;
          seq   <= '0;
          state <= cfg_ttl == '0 ? DROP : SEND;
        end
        SEND: if (out_ready) begin
          seq         <= last ? '0 : seq + 1'b1;
          encode_done <= last;
          state       <= last ? IDLE : SEND;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_encode_packet_flex.sv
// tb_encode_packet_flex: directed checks of flit content, backpressure, drop, back-to-back, reset abort and a narrow geometry
module tb_encode_packet_flex;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1023:0] in_data = '0;
  logic [9:0]    in_dst_addr = '0;
  logic [1:0]    cfg_ttl = '0;
  logic [1:0]    cfg_src_id = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [63:0]   out_data;
  logic          out_last;
  logic          busy;
  logic          encode_done;
  logic          drop_pulse;

  logic          s_in_valid = 1'b0;
  logic          s_in_ready;
  logic [255:0]  s_in_data = '0;
  logic [7:0]    s_in_dst_addr = '0;
  logic          s_out_valid;
  logic [31:0]   s_out_data;
  logic          s_out_last;
  logic          s_busy;
  logic          s_encode_done;
  logic          s_drop_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0]   f0, fl;
  logic [1023:0] inc;

  always #5 clk = ~clk;

  encode_packet_flex dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dst_addr(in_dst_addr), .cfg_ttl(cfg_ttl), .cfg_src_id(cfg_src_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .encode_done(encode_done), .drop_pulse(drop_pulse)
  );

  encode_packet_flex #(.DATA_WIDTH(256), .ADDR_WIDTH(8), .FLIT_WIDTH(32)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_dst_addr(s_in_dst_addr), .cfg_ttl(2'd2), .cfg_src_id(2'd3),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data), .out_last(s_out_last),
    .busy(s_busy), .encode_done(s_encode_done), .drop_pulse(s_drop_pulse)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_flit(input logic [1033:0] fr, input logic [1:0] t, input int k, input logic [1:0] s);
    logic [1044:0] pf;
    logic [54:0]   p;
    logic [4:0]    q;
    pf = {11'b0, fr};
    for (int b = 0; b < 55; b++) p[b] = pf[k*55 + b];
    q = 5'(k);
    return {p, t, q, s};
  endfunction

  // called at a negedge with the encoder idle or about to be; returns at the negedge where encode_done shows
  task automatic send(input logic [1023:0] d, input logic [9:0] a, input logic [1:0] t, input logic [1:0] s, input bit bp);
    logic [63:0] held;
    bit          stalled;
    int          k, g;
    in_data = d; in_dst_addr = a; cfg_ttl = t; cfg_src_id = s; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    chk("in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; in_data = ~d; in_dst_addr = ~a; cfg_src_id = ~s; cfg_ttl = 2'd1;
    chk("first_valid", out_valid, 1);
    k = 0; stalled = 0; held = '0;
    for (int c = 0; c < 400 && k < 19; c++) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) chk("stall_hold", out_data, held);
      chk("valid_mid", out_valid, 1);
      if (out_ready) begin
        chk($sformatf("flit%0d", k), out_data, exp_flit({d, a}, t, k, s));
        chk($sformatf("last%0d", k), out_last, k == 18);
        if (k == 0) f0 = out_data;
        if (k == 18) fl = out_data;
        k++; stalled = 0;
      end else begin
        held = out_data; stalled = 1;
      end
      @(negedge clk);
    end
    chk("flit_count", k, 19);
    chk("done_pulse", encode_done, 1);
    chk("valid_after", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) inc[i*8 +: 8] = 8'(i);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", in_ready, 1);

    send(inc, 10'h2A5, 2'd3, 2'd1, 0);
    chk("f0_hdr", f0[8:0], 9'b11_00000_01);
    chk("f0_addr", f0[18:9], 10'h2A5);
    chk("f18_pay", fl[52:9], 44'h7F7E7D7C7B7);
    chk("f18_pad", fl[63:53], 0);
    @(negedge clk);
    chk("done_once", encode_done, 0);

    send(inc, 10'h2A5, 2'd3, 2'd1, 1);
    @(negedge clk);
    chk("bp_done_once", encode_done, 0);

    in_data = {32{32'hDEADBEEF}}; cfg_ttl = 2'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("drop_pulse", drop_pulse, 1);
    chk("drop_no_valid", out_valid, 0);
    chk("drop_ready_low", in_ready, 0);
    @(negedge clk);
    chk("drop_pulse_end", drop_pulse, 0);
    chk("drop_ready_back", in_ready, 1);
    chk("drop_no_valid2", out_valid, 0);

    send({16{64'h0123456789ABCDEF}}, 10'h155, 2'd2, 2'd2, 0);
    chk("b2b_ready", in_ready, 1);
    send({16{64'hFEDCBA9876543210}}, 10'h0F0, 2'd1, 2'd3, 0);
    @(negedge clk);

    in_data = inc; in_dst_addr = 10'h3C3; cfg_ttl = 2'd2; cfg_src_id = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_rst_flit8", out_data, exp_flit({inc, 10'h3C3}, 2'd2, 8, 2'd2));
    rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_data", out_data, 0);
    chk("abort_last", out_last, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", in_ready, 0);
    @(negedge clk);
    chk("abort_no_done", encode_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send(~inc, 10'h011, 2'd3, 2'd0, 0);
    @(negedge clk);

    s_in_data = '1; s_in_dst_addr = 8'h5A; s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    chk("sw_first_valid", s_out_valid, 1);
    chk("sw_flit0", s_out_data, 32'hFFFEB503);
    begin
      int n = 0;
      while (!s_out_last && n < 40) begin @(negedge clk); n++; end
      chk("sw_last_idx", n, 11);
    end
    chk("sw_last_flit", s_out_data, 32'h000FFF2F);
    @(negedge clk);
    chk("sw_done", s_encode_done, 1);
    chk("sw_valid_off", s_out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
